pipe_dmem_responder: RTL and testbench

- Data-memory responder at the memory end of the pipelined CPU's load/store interface.
- Accepts one word-sized load or store request at a time from the pipeline's memory stage.
- Inserts a programmable number of wait states, then returns a response (read data or write acknowledge) over a valid/ready handshake.
- Gives the pipeline a realistic, non-zero-latency memory to stall against.

---
 rtl/pipe_mem_pkg.sv | 18 +
 rtl/pipe_dmem_array.sv | 45 ++++
 rtl/pipe_dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_pipe_dmem_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mem_pkg.sv
// rtl/pipe_mem_pkg.sv - shared types and constants for the pipeline data-memory responder
package pipe_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // resp_err is one bit today; named codes leave room for a wider error field later
    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_ADDR = 1'b1;

endpackage

// File: rtl/pipe_dmem_array.sv
// rtl/pipe_dmem_array.sv - word storage with async clear, one write port, one registered read port
import pipe_mem_pkg::*;

module pipe_dmem_array #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic              i_rd_sel,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Storage: cleared by reset, otherwise written only when the top commits a good store
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Read register: loads the addressed word when i_rd_sel, otherwise loads zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_sel ? r_mem[i_rd_idx] : '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pipe_dmem_responder.sv
// rtl/pipe_dmem_responder.sv - single-outstanding load/store responder with programmable wait states
import pipe_mem_pkg::*;

module pipe_dmem_responder #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                  r_state;
    state_e                  w_next_state;
    logic [WAIT_CNT_W-1:0]   r_cnt;
    logic                    r_we;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_resp_valid;
    logic                    r_resp_err;

    logic                    w_accept;
    logic                    w_enter_resp;
    logic                    w_handshake;
    logic                    w_we;
    logic [ADDR_W-1:0]       w_addr;
    logic [DATA_W-1:0]       w_wdata;
    logic [ADDR_W-3:0]       w_word;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_err;

    // With zero wait states RESP is entered on the acceptance edge itself, before the
    // capture registers hold the request, so the live inputs are used while in IDLE
    assign w_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_word  = w_addr[ADDR_W-1:2];
    assign w_idx   = w_addr[IDX_W+1:2];

    // Misaligned or beyond the last word: no aliasing onto low words
    assign w_err = ((w_addr[1:0] != 2'b00) || (32'(w_word) >= 32'(DEPTH))) ? ERR_ADDR : ERR_NONE;

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;

    // Next-state decode and the per-edge strobes that drive the datapath
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_handshake  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Wait-state counter: loaded on acceptance, counts down while waiting
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= 4'(WAIT_CYCLES);
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture, only while IDLE so a held or changing request is ignored later
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Response flags: set on RESP entry, cleared by the response handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= ERR_NONE;
        end else if (w_enter_resp) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
        end else if (w_handshake) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= ERR_NONE;
        end
    end

    // The array's read register is the resp_rdata register: loaded with the word for a good
    // load on RESP entry, zero for stores/errors, and cleared again on the handshake
    pipe_dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_wr_en   (w_enter_resp && w_we && !w_err),
        .i_wr_idx  (w_idx),
        .i_wr_data (w_wdata),
        .i_rd_en   (w_enter_resp || w_handshake),
        .i_rd_sel  (w_enter_resp && !w_we && !w_err),
        .i_rd_idx  (w_idx),
        .o_rd_data (resp_rdata)
    );

endmodule

// File: tb/tb_pipe_dmem_responder.sv
// tb/tb_pipe_dmem_responder.sv - randomized self-checking bench for pipe_dmem_responder
module tb_pipe_dmem_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic        resp_err   [3];
    logic [31:0] resp_rdata [3];
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;

    int          errors = 0;
    int          checks = 0;
    int          wc [3] = '{2, 0, 15};
    logic [31:0] mdl [3][64];

    always #5 clock = ~clock;

    pipe_dmem_responder #(.WAIT_CYCLES(2)) dut_w2 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

    pipe_dmem_responder #(.WAIT_CYCLES(0)) dut_w0 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

    pipe_dmem_responder #(.WAIT_CYCLES(15)) dut_w15 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[2]),
        .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

    function automatic logic model_err(input logic [15:0] a);
        return (a % 4 != 0) || (a / 4 >= 64);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 64; i++)
                mdl[k][i] = 32'h0;
    endtask

    // Driver: issue one request to instance k, measure latency, optionally stall the
    // response for hold cycles (scrambling req_valid/req_addr), then complete it.
    // Starts and ends on a falling edge.
    task automatic txn(input int k, input logic we, input logic [15:0] a, input logic [31:0] wd,
                       input int hold, input bit toggle,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int rdy_low, output bit stable);
        int guard;
        guard = 0;
        while (!req_ready[k] && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        req_we = we; req_addr = a; req_wdata = wd;
        req_valid[k] = 1'b1; resp_ready[k] = 1'b0;
        @(posedge clock);
        #1 req_valid[k] = 1'b0;
        lat = -1; rdy_low = 0; stable = 1'b1; rd = 'x; er = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (!req_ready[k]) rdy_low++;
            if (resp_valid[k] === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) return;
        rd = resp_rdata[k];
        er = resp_err[k];
        for (int h = 0; h < hold; h++) begin
            if (toggle) begin
                req_valid[k] = 1'($urandom);
                req_addr = 16'($urandom);
            end
            @(negedge clock);
            if (!req_ready[k]) rdy_low++;
            if (resp_valid[k] !== 1'b1 || resp_rdata[k] !== rd || resp_err[k] !== er || req_ready[k] !== 1'b0)
                stable = 1'b0;
        end
        req_valid[k] = 1'b0;
        resp_ready[k] = 1'b1;
        @(posedge clock);
        #1 resp_ready[k] = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            resp_ready[k] = 1'b0;
        end
        clear_model();
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0 || resp_rdata[k] !== 32'h0 || resp_err[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: ready=%b valid=%b rdata=%h err=%b, need 1 0 0 0",
                         k, req_ready[k], resp_valid[k], resp_rdata[k], resp_err[k]);
            end
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_first_load();
        logic [31:0] rd; logic er; int lat, rl; bit st;
        txn(0, 1'b0, 16'h0000, 32'h0, 0, 1'b0, rd, er, lat, rl, st);
        checks++;
        if (lat !== 3 || rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL first_load: lat=%0d rdata=%h err=%b, need 3 00000000 0", lat, rd, er);
        end
        checks++;
        if (rl !== 3 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL first_load_ready_low: low=%0d ready_after=%b, need 3 1", rl, req_ready[0]);
        end
        checks++;
        if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL post_handshake_clear: valid=%b rdata=%h, need 0 00000000", resp_valid[0], resp_rdata[0]);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat, rl; bit st;
        txn(0, 1'b1, 16'h0004, 32'h0000000F, 0, 1'b0, rd, er, lat, rl, st);
        mdl[0][1] = 32'h0000000F;
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL store_resp: rdata=%h err=%b lat=%0d, need 00000000 0 3", rd, er, lat);
        end
        txn(0, 1'b0, 16'h0004, 32'h0, 0, 1'b0, rd, er, lat, rl, st);
        checks++;
        if (rd !== mdl[0][1] || er !== 1'b0) begin
            errors++;
            $display("FAIL load_after_store: rdata=%h err=%b, need %h 0", rd, er, mdl[0][1]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat, rl; bit st;
        txn(0, 1'b0, 16'h0004, 32'h0, 5, 1'b1, rd, er, lat, rl, st);
        checks++;
        if (rd !== 32'h0000000F || er !== 1'b0 || st !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_hold: rdata=%h err=%b stable=%b, need 0000000f 0 1", rd, er, st);
        end
        checks++;
        if (rl !== 8 || req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_no_reaccept: low=%0d ready=%b valid=%b, need 8 1 0",
                     rl, req_ready[0], resp_valid[0]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, rl; bit st;
        logic [31:0] wd;
        txn(0, 1'b0, 16'h0006, 32'h0, 0, 1'b0, rd, er, lat, rl, st);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL misaligned_load: err=%b rdata=%h, need 1 00000000", er, rd);
        end
        wd = $urandom;
        txn(0, 1'b1, 16'h00FC, wd, 0, 1'b0, rd, er, lat, rl, st);
        mdl[0][63] = wd;
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL top_word_store: err=%b rdata=%h, need 0 00000000", er, rd);
        end
        txn(0, 1'b0, 16'h00FC, 32'h0, 0, 1'b0, rd, er, lat, rl, st);
        checks++;
        if (er !== 1'b0 || rd !== mdl[0][63]) begin
            errors++;
            $display("FAIL top_word_load: err=%b rdata=%h, need 0 %h", er, rd, mdl[0][63]);
        end
        txn(0, 1'b1, 16'h0000, 32'hA5A5A5A5, 0, 1'b0, rd, er, lat, rl, st);
        mdl[0][0] = 32'hA5A5A5A5;
        txn(0, 1'b1, 16'h0100, 32'h12345678, 0, 1'b0, rd, er, lat, rl, st);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL out_of_range_store: err=%b rdata=%h, need 1 00000000", er, rd);
        end
        txn(0, 1'b0, 16'h0000, 32'h0, 0, 1'b0, rd, er, lat, rl, st);
        checks++;
        if (er !== 1'b0 || rd !== mdl[0][0]) begin
            errors++;
            $display("FAIL no_alias_after_oor: err=%b rdata=%h, need 0 %h", er, rd, mdl[0][0]);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat, rl; bit st;
        req_we = 1'b1; req_addr = 16'h0008; req_wdata = 32'h00000007;
        req_valid[0] = 1'b1;
        @(posedge clock);
        #1 req_valid[0] = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait_entered: ready=%b, need 0", req_ready[0]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'h0 || resp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ready=%b valid=%b rdata=%h err=%b, need 1 0 0 0",
                     req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0]);
        end
        clear_model();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        txn(0, 1'b0, 16'h0008, 32'h0, 0, 1'b0, rd, er, lat, rl, st);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL aborted_store: rdata=%h err=%b, need 00000000 0", rd, er);
        end
        txn(0, 1'b0, 16'h0004, 32'h0, 0, 1'b0, rd, er, lat, rl, st);
        checks++;
        if (rd !== mdl[0][1]) begin
            errors++;
            $display("FAIL reset_clears_array: rdata=%h, need %h", rd, mdl[0][1]);
        end
    endtask

    task automatic test_latency_sweep();
        logic [31:0] rd; logic er; int lat, rl; bit st;
        for (int k = 1; k < 3; k++) begin
            txn(k, 1'b0, 16'h0000, 32'h0, 0, 1'b0, rd, er, lat, rl, st);
            checks++;
            if (lat !== wc[k] + 1 || rl !== wc[k] + 1 || rd !== 32'h0 || er !== 1'b0) begin
                errors++;
                $display("FAIL latency_sweep W=%0d: lat=%0d low=%0d rdata=%h err=%b, need %0d %0d 0 0",
                         wc[k], lat, rl, rd, er, wc[k] + 1, wc[k] + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat, rl; bit st;
        logic [31:0] wd, exp_rd;
        logic [15:0] a;
        logic        we, exp_er;
        int          k, mode, hold;
        for (int n = 0; n < 60; n++) begin
            k    = int'($urandom_range(0, 1));
            we   = 1'($urandom);
            wd   = $urandom;
            hold = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 9));
            if (mode < 7)       a = 16'($urandom_range(0, 7) * 4);
            else if (mode == 7) a = 16'($urandom_range(0, 63) * 4);
            else if (mode == 8) a = 16'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
            else                a = 16'($urandom_range(64, 16383) * 4);
            exp_er = model_err(a);
            exp_rd = (we || exp_er) ? 32'h0 : mdl[k][a / 4];
            if (we && !exp_er) mdl[k][a / 4] = wd;
            txn(k, we, a, wd, hold, 1'b1, rd, er, lat, rl, st);
            checks++;
            if (rd !== exp_rd || er !== exp_er || lat !== wc[k] + 1 || st !== 1'b1) begin
                errors++;
                $display("FAIL random#%0d inst%0d we=%b a=%h: rdata=%h err=%b lat=%0d stable=%b, need %h %b %0d 1",
                         n, k, we, a, rd, er, lat, st, exp_rd, exp_er, wc[k] + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_store_load();
        test_backpressure();
        test_errors();
        test_reset_mid_wait();
        test_latency_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
